apb_cmd_master: RTL

Parametrised APB master that replaces the fixed single-command master used by `apb_top`. Sits between a command producer and one APB slave. Queues commands in a `DEPTH`-entry FIFO, issues them as back-to-back APB transfers with wait-state support, and reports each completion with a status code: OK, slave error, or timeout.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_cmd_master_if.sv | 39 +++
 rtl/apb_cmd_fifo.sv | 53 +++++
 rtl/apb_cmd_master.sv | 137 +++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB master types: FSM states, completion status codes and counter sizing.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_SLVERR  = 2'b01,
        RSP_TIMEOUT = 2'b10
    } apb_rsp_e;

    // A disabled timeout (0) still needs a legal 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signals of apb_cmd_master: master = the block itself, slave = producer, consumer and APB slave.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_write_i;
    logic [ADDR_W-1:0]       cmd_addr_i;
    logic [DATA_W-1:0]       cmd_wdata_i;
    logic                    rsp_valid_o;
    logic [1:0]              rsp_code_o;
    logic [DATA_W-1:0]       rsp_rdata_o;
    logic [$clog2(DEPTH):0]  level_o;
    logic                    busy_o;
    logic                    psel_o;
    logic                    penable_o;
    logic                    pwrite_o;
    logic [ADDR_W-1:0]       paddr_o;
    logic [DATA_W-1:0]       pwdata_o;
    logic [DATA_W-1:0]       prdata_i;
    logic                    pready_i;
    logic                    pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output cmd_ready_o, rsp_valid_o, rsp_code_o, rsp_rdata_o, level_o, busy_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_code_o, rsp_rdata_o, level_o, busy_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Command FIFO: registered level, head visible combinationally (0-cycle read), push refused while full even with a pop.
module apb_cmd_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LVL_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = cnt;

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/apb_cmd_master.sv
// APB master issuing queued commands; accept-to-response 3 cycles plus wait states, 2 cycles per back-to-back transfer.
// cmd_ready_o drops while the FIFO is full; responses are single-cycle pulses with no backpressure.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input logic              pclk,
    input logic              preset,
    apb_cmd_master_if.master bus
);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t              fifo_in;
    cmd_t              fifo_out;
    cmd_t              cmd_q;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              pop;
    logic              done;
    logic              abort;
    logic              tmo_hit;
    apb_state_e        state_q;
    apb_state_e        state_d;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic              rsp_valid_q;
    apb_rsp_e          rsp_code_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign fifo_in = '{write: bus.cmd_write_i, addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i};

    apb_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .pclk   (pclk),
        .preset (preset),
        .push   (bus.cmd_valid_i),
        .wdata  (fifo_in),
        .pop    (pop),
        .rdata  (fifo_out),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    // Counter holds TIMEOUT-1 on the TIMEOUT-th consecutive not-ready ACCESS cycle.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SETUP;
                    pop     = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready_i) begin
                    done = 1'b1;
                    if (!empty) begin
                        state_d = SETUP;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            cmd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cmd_q     <= fifo_out;
                tmo_cnt_q <= '0;
            end else if (state_q == ACCESS && !bus.pready_i) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    // Read data only survives a clean read; writes, errors and timeouts report zero.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_OK;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done || abort;
            if (done) begin
                rsp_code_q  <= bus.pslverr_i ? RSP_SLVERR : RSP_OK;
                rsp_rdata_q <= (!cmd_q.write && !bus.pslverr_i) ? bus.prdata_i : '0;
            end else if (abort) begin
                rsp_code_q  <= RSP_TIMEOUT;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.cmd_ready_o = !full;
    assign bus.level_o     = level;
    assign bus.busy_o      = (state_q != IDLE) || !empty;
    assign bus.psel_o      = (state_q != IDLE);
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.pwrite_o    = cmd_q.write;
    assign bus.paddr_o     = cmd_q.addr;
    assign bus.pwdata_o    = cmd_q.wdata;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_code_o  = rsp_code_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
endmodule
